mux_arb_reg: RTL and testbench
==============================

// Module: mux_arb_reg
// PURPOSE
//  Parametrised N-input, W-bit selector with registered output and valid/ready handshake.
//  Successor to the 16-bit 2:1 datapath mux. Adds N inputs, registered output, flow control and round-robin mode.
//  Merges multiple producers (ALU result, memory read, immediate, forwarding paths) onto one pipelined consumer.
//  Mode 0 is explicit select; mode 1 is round-robin fair arbitration among valid inputs.
// PARAMETERS
//  WIDTH    16  data width per channel, >=1
//  NUM_IN   4   number of input channels, >=2
//  SEL_W    $clog2(NUM_IN)  select/source index width (localparam, not overridable)
// PORTS
//  clk       in   1              clock, all state on rising edge
//  rst_n     in   1              asynchronous active-low reset
//  in_data   in   NUM_IN*WIDTH   packed inputs, channel i at [i*WIDTH +: WIDTH]
//  in_valid  in   NUM_IN         channel i has data
//  in_ready  out  NUM_IN         channel i accepted this cycle (valid&ready = transfer)
//  mode_rr   in   1              0 = explicit select, 1 = round-robin
//  sel       in   SEL_W          channel index used when mode_rr=0
//  out_data  out  WIDTH          registered selected data
//  out_src   out  SEL_W          index of the channel that produced out_data
//  out_valid out  1              out_data/out_src valid
//  out_ready in   1              consumer accepts (transfer when out_valid&out_ready)
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1.
//  With rr_ptr=NUM_IN-1, channel 0 has first priority after reset.
//  Output stage is one register with states EMPTY (out_valid=0) and FULL (out_valid=1).
//  load_ok = !out_valid | out_ready. The register accepts new data when load_ok=1 (combinational, full throughput).
//  Grant (one-hot, combinational):
//   - mode_rr=0: grant[sel]=in_valid[sel]. If sel>=NUM_IN, grant=0 (no transfer, no error).
//   - mode_rr=1: first valid channel scanning rr_ptr+1, rr_ptr+2, ... with modulo-NUM_IN wrap; grant=0 if no channel is valid.
//  in_ready[i] = grant[i] & load_ok. At most one bit of in_ready is set per cycle.
//  in_ready does not depend on in_valid of other channels beyond the grant logic.
//  Transfer in: on the clock edge, out_data<=chosen data, out_src<=granted index, out_valid<=1.
//  In RR mode, rr_ptr<=granted index.
//  Latency: input transfer at edge k gives out_valid=1 from edge k onward, i.e. 1 cycle.
//  Transitions:
//   - EMPTY -> FULL on a grant.
//   - FULL -> FULL on out_ready & grant (back-to-back, one word per cycle).
//   - FULL -> EMPTY on out_ready & no grant.
//   - FULL holds on !out_ready: out_data and out_src stay stable, all in_ready=0.
//  rr_ptr changes only on an input transfer in RR mode. Explicit mode leaves rr_ptr untouched.
//  mode_rr and sel changes take effect on the next grant evaluation. They never alter a held output word.
//  Simultaneous out transfer and in transfer in the same cycle: the old word leaves and the new word loads.
//  No bubble and no duplication.
//  Reset mid-transfer: any held word is discarded and the block returns to EMPTY immediately. rr_ptr is reinitialised.
//  out_data is driven only from the register: no combinational input-to-output path.
//  in_ready combinationally depends on out_ready, sel, mode_rr and in_valid only.
// TESTING
//  1. Reset: rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_data=0, out_src=0 without waiting for a clock edge.
//  2. Explicit mode: mode_rr=0, sel=2, in_data ch2=16'hBEEF, in_valid=4'b1111, out_ready=1
//     -> in_ready=4'b0100; next cycle out_data=16'hBEEF, out_src=2. sel=3'd5 (NUM_IN=5) -> in_ready=0.
//  3. Backpressure: fill the output, then out_ready=0 for 3 cycles with ch1 valid
//     -> out_data stable, in_ready=0 each cycle; out_ready=1 -> ch1 word appears the following cycle, no loss.
//  4. Round-robin: mode_rr=1, all 4 channels valid continuously, out_ready=1
//     -> out_src sequence 0,1,2,3,0,1 after reset; with only ch0 and ch3 valid -> 0,3,0,3.
//  5. Throughput/simultaneity: 100 random words, out_ready random 50%
//     -> scoreboard matches in order per grant, no duplicates or drops; 1 word/cycle when out_ready=1 continuously.
//  6. Mode switch while FULL and stalled: held word unchanged; first grant after release follows the new mode.

Source files
------------

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-input, WIDTH-bit selector with a one-word registered output
// stage and valid/ready flow control on both sides.
//   mode_rr=0 : explicit select, channel 'sel' is granted when it is valid
//   mode_rr=1 : round-robin among valid channels, starting after rr_ptr
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_data[NUM_IN*WIDTH] packed channel data, ch i at [i*WIDTH +: WIDTH]
//   in_valid/in_ready     per-channel handshake (in_ready is one-hot or zero)
//   mode_rr, sel          arbitration mode and explicit channel index
//   out_data/out_src      registered word and the channel it came from
//   out_valid/out_ready   consumer handshake
module mux_arb_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode_rr,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [SEL_W-1:0]   r_src;
  logic [SEL_W-1:0]   r_rr_ptr;

  logic [NUM_IN-1:0]  w_gnt;
  logic [SEL_W-1:0]   w_gnt_idx;
  logic [WIDTH-1:0]   w_gnt_data;
  logic               w_load_ok;
  logic               w_xfer_in;

  // Grant. In explicit mode an out-of-range sel matches no channel, so the
  // grant is simply zero. In RR mode scan rr_ptr+1 .. rr_ptr+NUM_IN with wrap.
  always_comb begin
    logic             found;
    int               idx;
    logic [SEL_W-1:0] rr_idx;
    w_gnt  = '0;
    found  = 1'b0;
    idx    = 0;
    rr_idx = '0;
    if (!mode_rr) begin
      for (int i = 0; i < NUM_IN; i++)
        if (sel == SEL_W'(i)) w_gnt[i] = in_valid[i];
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        rr_idx = SEL_W'(idx);
        if (!found && in_valid[rr_idx]) begin
          found         = 1'b1;
          w_gnt[rr_idx] = 1'b1;
        end
      end
    end
  end

  // One-hot grant -> index and data (AND-OR mux, grant is at most one-hot).
  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = w_gnt_idx | SEL_W'(i);
        w_gnt_data = w_gnt_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The register can take a word when empty, or when its current word leaves
  // this same cycle; this gives one word per cycle with no bubble.
  assign w_load_ok = (r_state == EMPTY) | out_ready;
  assign w_xfer_in = w_load_ok & (|w_gnt);

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_rdy
    assign in_ready[gi] = w_gnt[gi] & w_load_ok;
  end

  // Output stage FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (|w_gnt) w_state_nxt = FULL;
      FULL:    if (out_ready) w_state_nxt = (|w_gnt) ? FULL : EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Datapath. rr_ptr starts at NUM_IN-1 so channel 0 wins first after reset,
  // and only moves on an accepted word in RR mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_src    <= '0;
      r_rr_ptr <= SEL_W'(NUM_IN - 1);
    end else if (w_xfer_in) begin
      r_data <= w_gnt_data;
      r_src  <= w_gnt_idx;
      if (mode_rr) r_rr_ptr <= w_gnt_idx;
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed and scoreboard bench for mux_arb_reg. A second instance with
// NUM_IN=5 covers the out-of-range explicit select.
module tb_mux_arb_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode_rr;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_valid, out_ready;

  logic [79:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic [2:0]  sel5;
  logic [15:0] out_data5;
  logic [2:0]  out_src5;
  logic        out_valid5;

  mux_arb_reg #(.WIDTH(16), .NUM_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode_rr(mode_rr), .sel(sel), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready));

  mux_arb_reg #(.WIDTH(16), .NUM_IN(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode_rr(1'b0), .sel(sel5), .out_data(out_data5),
    .out_src(out_src5), .out_valid(out_valid5), .out_ready(1'b1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  int          exp_rr[6]  = '{0, 1, 2, 3, 0, 1};
  int          exp_rr2[4] = '{0, 3, 0, 3};
  logic [15:0] cur[4];
  logic [15:0] q_data[$];
  logic [1:0]  q_src[$];
  logic [3:0]  xfer;
  logic [1:0]  prev_src;

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode_rr = 1'b0; sel = '0; out_ready = 1'b1;
    in_data5 = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    in_valid5 = '0; sel5 = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_src",   32'(out_src), 0);
    #2 rst_n = 1'b1;
    tick();

    // Explicit select
    mode_rr = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    sel5 = 3'd5; in_valid5 = 5'b11111;
    #1;
    chk("exp_rdy", 32'(in_ready), 32'b0100);
    chk("exp5_rdy_oor", 32'(in_ready5), 0);
    tick();
    chk("exp_data", 32'(out_data), 32'hBEEF);
    chk("exp_src",  32'(out_src), 2);
    chk("exp_vld",  32'(out_valid), 1);
    chk("exp5_vld_oor", 32'(out_valid5), 0);
    sel5 = 3'd4;
    #1;
    chk("exp5_rdy4", 32'(in_ready5), 32'b10000);
    tick();
    chk("exp5_src4",  32'(out_src5), 4);
    chk("exp5_data4", 32'(out_data5), 32'h4444);

    // Asynchronous reset while holding a word
    in_valid = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data",  32'(out_data), 0);
    chk("arst_src",   32'(out_src), 0);
    rst_n = 1'b1;
    tick();

    // Backpressure
    mode_rr = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    in_data = {16'h0, 16'h0, 16'h1111, 16'h0};
    tick();
    chk("bp_fill", 32'(out_data), 32'h1111);
    in_data = {16'h0, 16'h0, 16'h2222, 16'h0};
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rdy0", 32'(in_ready), 0);
      tick();
      chk("bp_hold", 32'(out_data), 32'h1111);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(in_ready), 32'b0010);
    tick();
    chk("bp_new", 32'(out_data), 32'h2222);
    in_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    // Round-robin, all valid
    do_reset();
    mode_rr = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    #1;
    chk("rr_first_rdy", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_src",  32'(out_src), 32'(exp_rr[k]));
      chk("rr_data", 32'(out_data), 32'hA000 + 32'(exp_rr[k]));
    end

    // Round-robin, ch0 and ch3 only
    in_valid = '0;
    do_reset();
    mode_rr = 1'b1; in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr2_src", 32'(out_src), 32'(exp_rr2[k]));
    end

    // Mode switch while full and stalled; explicit mode left rr_ptr at reset value
    in_valid = '0;
    do_reset();
    mode_rr = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    tick();
    chk("ms_load", 32'(out_src), 2);
    out_ready = 1'b0; mode_rr = 1'b1; in_valid = 4'b1111;
    in_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    #1;
    chk("ms_rdy0", 32'(in_ready), 0);
    tick();
    tick();
    chk("ms_hold_data", 32'(out_data), 32'hC002);
    chk("ms_hold_src",  32'(out_src), 2);
    out_ready = 1'b1;
    #1;
    chk("ms_rdy_rr", 32'(in_ready), 32'b0001);
    tick();
    chk("ms_src",  32'(out_src), 0);
    chk("ms_data", 32'(out_data), 32'hD000);

    // Random traffic with scoreboard
    in_valid = '0;
    do_reset();
    for (int i = 0; i < 4; i++) cur[i] = 16'(i << 12);
    begin
      int cyc = 0;
      int n_in = 0;
      while (n_in < 100 && cyc < 3000) begin
        in_valid  = 4'($urandom);
        out_ready = 1'($urandom);
        mode_rr   = 1'($urandom);
        sel       = 2'($urandom);
        in_data   = {cur[3], cur[2], cur[1], cur[0]};
        #1;
        chk("rnd_rdy_sub", 32'(in_ready & ~in_valid), 0);
        if (out_valid && !out_ready) chk("rnd_stall_rdy", 32'(in_ready), 0);
        if (out_valid && out_ready) begin
          if (q_data.size() == 0) chk("rnd_sb_empty", 1, 0);
          else begin
            chk("rnd_data", 32'(out_data), 32'(q_data.pop_front()));
            chk("rnd_src",  32'(out_src), 32'(q_src.pop_front()));
          end
        end
        xfer = in_valid & in_ready;
        if (xfer != 0) begin
          chk("rnd_onehot", 32'($onehot(xfer)), 1);
          for (int i = 0; i < 4; i++) if (xfer[i]) begin
            q_data.push_back(cur[i]);
            q_src.push_back(2'(i));
            cur[i] = cur[i] + 16'd1;
            n_in++;
          end
        end
        tick();
        cyc++;
      end
      chk("rnd_count", 32'(n_in), 100);
      in_valid = '0; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        #1;
        if (out_valid) begin
          if (q_data.size() == 0) chk("drn_sb_empty", 1, 0);
          else begin
            chk("drn_data", 32'(out_data), 32'(q_data.pop_front()));
            chk("drn_src",  32'(out_src), 32'(q_src.pop_front()));
          end
        end
        tick();
      end
      chk("drn_left", 32'(q_data.size()), 0);
      chk("drn_vld",  32'(out_valid), 0);
    end

    // Full throughput: one word per cycle with continuous out_ready
    mode_rr = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    prev_src = out_src;
    for (int c = 0; c < 8; c++) begin
      chk("thr_vld", 32'(out_valid), 1);
      chk("thr_rdy_any", 32'(in_ready != 0), 1);
      tick();
      chk("thr_src", 32'(out_src), 32'(2'(prev_src + 2'd1)));
      prev_src = out_src;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
